// File: rtl/disp7seg_reloj_if.sv
// Digit inputs and display outputs of the multiplexed 7-segment driver.
// The clock state machine is the master; the display driver is the slave.
interface disp7seg_reloj_if;
  logic [3:0] e0;
  logic [3:0] e1;
  logic [3:0] e2;
  logic [3:0] e3;
  logic       blank_lz;
  logic       tick_half;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame;

  modport master (
    output e0, e1, e2, e3, blank_lz, tick_half,
    input  seg, an, dp, frame
  );

  modport slave (
    input  e0, e1, e2, e3, blank_lz, tick_half,
    output seg, an, dp, frame
  );
endinterface

// File: rtl/disp7seg_reloj.sv
// Four-digit multiplexed common-anode 7-segment driver with per-frame digit snapshot,
// leading-zero blanking, blinking colon and frame-start pulse. All outputs registered.
module disp7seg_reloj #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic            clk,
  input  logic            rst,
  disp7seg_reloj_if.slave disp_io
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCyc = CntW'(BLANK_CYC);

  // Active-low {g,f,e,d,c,b,a}; anything that is not valid BCD shows a dash.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h3F;
    endcase
    return p;
  endfunction

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] s_q, s_d;
  logic            colon_q, colon_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            frame_q, frame_d;

  logic snap;
  logic wrap;
  logic lz_blank;

  always_comb begin
    snap      = (idx_q == 2'd0) && (div_cnt_q == '0);
    wrap      = (div_cnt_q == CntMax);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q + {1'b0, wrap};

    s_d = s_q;
    if (snap) begin
      s_d = {disp_io.e3, disp_io.e2, disp_io.e1, disp_io.e0};
    end

    colon_d = colon_q ^ disp_io.tick_half;

    // Outputs use next-state shadows so the freshly loaded digit 0 shows with the frame pulse.
    seg_d    = dec7(s_d[idx_q]);
    lz_blank = (idx_q == 2'd3) && disp_io.blank_lz && (s_d[3] == 4'd0);
    an_d     = 4'hF;
    if ((div_cnt_q >= BlankCyc) && !lz_blank) begin
      an_d = ~(4'b0001 << idx_q);
    end
    dp_d    = !((idx_q == 2'd2) && colon_q && !an_d[2]);
    frame_d = snap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      s_q       <= '0;
      colon_q   <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      s_q       <= s_d;
      colon_q   <= colon_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign disp_io.seg   = seg_q;
  assign disp_io.an    = an_q;
  assign disp_io.dp    = dp_q;
  assign disp_io.frame = frame_q;

endmodule

// File: tb/tb_disp7seg_reloj.sv
// Scoreboard bench for disp7seg_reloj: directed stimulus queues one expected record per
// scan frame; a monitor aligns to each frame pulse and checks every cycle of the frame.
module tb_disp7seg_reloj;

  localparam int unsigned RefreshDiv = 8;
  localparam int unsigned BlankCyc   = 2;
  localparam int          FrameLen   = 32;
  localparam int          NumRec     = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp7seg_reloj_if bus ();

  disp7seg_reloj #(
    .REFRESH_DIV(RefreshDiv),
    .BLANK_CYC  (BlankCyc)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .disp_io(bus)
  );

  typedef struct {
    logic [3:0][6:0] seg;
    logic [3:0][3:0] an;
    bit              dp_on;
    int              ncyc;
    bit              contig;
  } rec_t;

  rec_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_done = 1'b0;
  int   c        = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic rec_t mk(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] a3, input bit dp,
                              input int n, input bit ct);
    rec_t r;
    r.seg    = {s3, s2, s1, s0};
    r.an     = {a3, 4'hB, 4'hD, 4'hE};
    r.dp_on  = dp;
    r.ncyc   = n;
    r.contig = ct;
    return r;
  endfunction

  task automatic go(input int target);
    while (c < target) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Stimulus
  initial begin
    bus.e0 = 4'd4; bus.e1 = 4'd3; bus.e2 = 4'd2; bus.e3 = 4'd1;
    bus.blank_lz = 1'b0; bus.tick_half = 1'b0;

    q.push_back(mk(7'h19, 7'h30, 7'h24, 7'h79, 4'h7, 1'b0, FrameLen, 1'b0));
    q.push_back(mk(7'h12, 7'h30, 7'h24, 7'h79, 4'h7, 1'b1, FrameLen, 1'b1));
    q.push_back(mk(7'h12, 7'h30, 7'h24, 7'h40, 4'hF, 1'b1, FrameLen, 1'b1));
    q.push_back(mk(7'h12, 7'h3F, 7'h24, 7'h40, 4'h7, 1'b0, FrameLen, 1'b1));
    q.push_back(mk(7'h12, 7'h3F, 7'h24, 7'h40, 4'h7, 1'b0, 26, 1'b1));
    q.push_back(mk(7'h02, 7'h78, 7'h00, 7'h10, 4'h7, 1'b0, FrameLen, 1'b1));
    q.push_back(mk(7'h02, 7'h78, 7'h00, 7'h10, 4'h7, 1'b0, FrameLen, 1'b1));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    c   = 0;
    go(20);  bus.e0 = 4'd5;                          // slot 2 of frame 0: lands in frame 1
    go(36);  bus.tick_half = 1'b1;
    go(37);  bus.tick_half = 1'b0;
    go(52);  bus.e3 = 4'd0; bus.blank_lz = 1'b1;
    go(84);  bus.e1 = 4'hC;
    go(100); bus.tick_half = 1'b1;
    go(101); bus.tick_half = 1'b0;
    go(116); bus.blank_lz = 1'b0;
    go(148); bus.e0 = 4'd6; bus.e1 = 4'd7; bus.e2 = 4'd8; bus.e3 = 4'd9;
    go(154); rst = 1'b1; bus.tick_half = 1'b1;       // slot 3 of frame 4, colon is 0 here
    go(155); rst = 1'b0; bus.tick_half = 1'b0;
    c = 0;

    while (!mon_done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (!mon_done) chk("monitor completion", 1'b0, 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor
  initial begin
    rec_t r;
    int   n;
    bit   stop;
    bit   seg_bad[4], an_bad[4], dp_bad[4], fr_bad;
    logic [6:0] seg_act[4], seg_exp[4];
    logic [3:0] an_act[4], an_exp[4];
    logic       dp_act[4], dp_exp[4];
    logic [3:0] ea;
    logic       ed;
    int         s, dv;

    stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset seg",   bus.seg === 7'h7F, 32'(bus.seg), 32'h7F);
    chk("reset an",    bus.an === 4'hF,   32'(bus.an),  32'hF);
    chk("reset dp",    bus.dp === 1'b1,   32'(bus.dp),  32'h1);
    chk("reset frame", bus.frame === 1'b0, 32'(bus.frame), 32'h0);

    for (int rn = 0; rn < NumRec && !stop; rn++) begin
      r = q.pop_front();
      @(negedge clk);
      n = 0;
      while (bus.frame !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        chk($sformatf("f%0d frame pulse timeout", rn), 1'b0, 32'd0, 32'd1);
        stop = 1'b1;
      end else begin
        if (r.contig) chk($sformatf("f%0d frame period", rn), n == 0, 32'(n), 32'd0);
        fr_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
          seg_bad[k] = 1'b0; an_bad[k] = 1'b0; dp_bad[k] = 1'b0;
        end
        for (int i = 0; i < r.ncyc; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (bus.frame !== 1'b0) fr_bad = 1'b1;
          end
          s  = i / 8;
          dv = i % 8;
          ea = (dv < 2) ? 4'hF : r.an[s];
          ed = (s == 2 && dv >= 2 && r.dp_on) ? 1'b0 : 1'b1;
          if (bus.seg !== r.seg[s] && !seg_bad[s]) begin
            seg_bad[s] = 1'b1; seg_act[s] = bus.seg; seg_exp[s] = r.seg[s];
          end
          if (bus.an !== ea && !an_bad[s]) begin
            an_bad[s] = 1'b1; an_act[s] = bus.an; an_exp[s] = ea;
          end
          if (bus.dp !== ed && !dp_bad[s]) begin
            dp_bad[s] = 1'b1; dp_act[s] = bus.dp; dp_exp[s] = ed;
          end
        end
        chk($sformatf("f%0d frame single-cycle", rn), !fr_bad, 32'(fr_bad), 32'd0);
        for (int k = 0; k < 4; k++) begin
          if (k * 8 < r.ncyc) begin
            chk($sformatf("f%0d seg slot%0d", rn, k), !seg_bad[k], 32'(seg_act[k]),
                32'(seg_exp[k]));
            chk($sformatf("f%0d an slot%0d", rn, k), !an_bad[k], 32'(an_act[k]),
                32'(an_exp[k]));
            chk($sformatf("f%0d dp slot%0d", rn, k), !dp_bad[k], 32'(dp_act[k]),
                32'(dp_exp[k]));
          end
        end
        if (r.ncyc < FrameLen) begin
          @(negedge clk);
          chk($sformatf("f%0d mid reset seg", rn), bus.seg === 7'h7F, 32'(bus.seg), 32'h7F);
          chk($sformatf("f%0d mid reset an", rn), bus.an === 4'hF, 32'(bus.an), 32'hF);
          chk($sformatf("f%0d mid reset dp", rn), bus.dp === 1'b1, 32'(bus.dp), 32'h1);
          chk($sformatf("f%0d mid reset frame", rn), bus.frame === 1'b0, 32'(bus.frame),
              32'h0);
        end
      end
    end
    mon_done = 1'b1;
  end

endmodule

// File: doc/disp7seg_reloj.md
# disp7seg_reloj

Four-digit multiplexed 7-segment display driver for the alarm clock. Reads the BCD time digits produced by the clock state machine (minutes units/tens, hours units/tens) and scans them onto a common-anode display, one digit per refresh slot. Digits are snapshotted once per scan frame so a digit update mid-frame never tears the display. Also provides leading-zero blanking, a blinking colon and a frame-start pulse.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (1 ms at 50 MHz); must be ≥ 4.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- e0  in  4  minutes units, BCD
- e1  in  4  minutes tens, BCD
- e2  in  4  hours units, BCD
- e3  in  4  hours tens, BCD
- blank_lz  in  1  1 = blank hours-tens digit when it is 0
- tick_half  in  1  single-cycle pulse every 0.5 s; toggles the colon
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- an  out  4  anode enables, active low; an[k] selects digit ek
- dp  out  1  decimal point / colon, active low
- frame  out  1  one-cycle pulse at start of each scan frame

## Operation
- div_cnt: ceil(log2(REFRESH_DIV))-bit counter, 0..REFRESH_DIV-1, wraps to 0. On wrap, idx (2 bits) advances 0→1→2→3→0.
- Snapshot: in any cycle with idx==0 and div_cnt==0 (includes first cycle after reset release), s0..s3 ← e0..e3. Otherwise shadows hold. Inputs changing at any other time have no effect until the next frame.
- Decode of shadow s[idx] (active-low {g..a} hex): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10; 10–15 (invalid BCD) → 3F (dash, g only).
- Anode: an = ~(1<<idx) when div_cnt ≥ BLANK_CYC, else 1111. Exception: idx==3, blank_lz==1 and s3==0 → an stays 1111 for the whole slot (blank_lz sampled live, not snapshotted).
- seg driven with the decoded pattern for the whole slot (including blank interval); only an gates visibility.
- Colon: colon_on toggles on each tick_half pulse. dp = 0 only when idx==2, colon_on==1 and an[2]==0; else 1.
- frame = 1 for exactly one cycle per frame, the cycle in which the freshly loaded shadows first drive seg.

## Timing
- All outputs registered; seg/an/dp/frame reflect (idx, div_cnt, shadows, colon_on) of the previous cycle (1-cycle latency).
- Snapshot cycle N (idx 0, div_cnt 0): shadows valid from N+1; frame=1 and seg shows decode(new s0) in N+1.
- Slot length REFRESH_DIV cycles; frame period 4·REFRESH_DIV cycles; an[k] low for REFRESH_DIV−BLANK_CYC consecutive cycles per frame.
- Reset (rst high at a clk edge): div_cnt=0, idx=0, s0..s3=0, colon_on=0; outputs next cycle: seg=7F, an=1111, dp=1, frame=0. Reset mid-slot aborts the slot; scan restarts at digit 0 with a new snapshot in the first cycle after release.
- rst and tick_half in the same cycle: reset wins, colon_on=0.
- Two tick_half pulses in consecutive cycles: colon_on toggles twice (net unchanged).
- No combinational path from any input to any output.

## Test plan
Bench uses REFRESH_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
- Reset, e3..e0=1,2,3,4 -> after release: frame pulse 1 cycle after first snapshot; slot 0 seg=19, an 1111 for 2 cycles then 1110 for 6; slots 1,2,3 seg=30,24,79 with an=1101,1011,0111; frame repeats every 32 cycles.
- Change e0 from 4 to 5 at mid-frame (slot 2) -> current frame unchanged; next frame slot 0 seg=12.
- e3=0, blank_lz=1 -> an[3] never low in slot 3; blank_lz=0 -> slot 3 seg=40, an=0111 after blank interval.
- e1=4'hC -> slot 1 seg=3F (dash); other digits unaffected.
- tick_half pulse once -> dp=0 only during active part of slot 2 each frame; second pulse -> dp stays 1; tick_half coincident with rst -> dp stays 1.
- Assert rst for one cycle during slot 3 -> next cycle seg=7F, an=1111, dp=1; scan restarts at slot 0 with new snapshot and frame pulse.
